// File: rtl/adc_axis_pkg.sv
// Shared types and helpers for the ADC-to-AXI-Stream capture path.
//   state_e        : FSM state encoding exposed on the 3-bit state port
//   beat_t         : one stream beat (data + frame-end marker)
//   offset_to_twos : converts an offset-binary ADC sample to a 32-bit signed word
package adc_axis_pkg;

    localparam int unsigned ADC_W  = 14;
    localparam int unsigned AXIS_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3
    } state_e;

    typedef struct packed {
        logic [AXIS_W-1:0] tdata;
        logic              tlast;
    } beat_t;

    // Invert the MSB (offset binary -> two's complement), then sign-extend.
    function automatic logic [AXIS_W-1:0] offset_to_twos(input logic [ADC_W-1:0] s);
        logic [ADC_W-1:0] t;
        t = {~s[ADC_W-1], s[ADC_W-2:0]};
        return {{(AXIS_W - ADC_W){t[ADC_W-1]}}, t};
    endfunction

endpackage

// File: rtl/adc_clk_div.sv
// ADC conversion clock divider.
//   clk, rst_n : system clock, async active-low reset
//   clk_adc    : divided clock, high for the upper half of each DIV-cycle period
//   strobe     : one-cycle pulse in the last cycle of each period (before clk_adc falls)
module adc_clk_div
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_adc,
    output logic strobe
);

    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Free-running 0..DIV-1 counter.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_d = '0;
        end
    end

    // Outputs are decoded from the next count so they line up with cnt_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            clk_adc <= 1'b0;
            strobe  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clk_adc <= (cnt_d >= CNT_W'(DIV / 2));
            strobe  <= (cnt_d == CNT_W'(DIV - 1));
        end
    end

endmodule

// File: rtl/adc_to_axis_m.sv
// ADC sampler feeding an AXI4-Stream master with framed output.
//   m00_axis_aclk / m00_axis_aresetn : clock, async active-low reset
//   control       : [0] capture enable, [1] LNA enable, [2] ADC powerdown, [3] test mode
//   ADC_data      : 14-bit offset-binary sample
//   ClockToADC    : ADC conversion clock
//   ADC_powerdown, LNA_enable : direct copies of control[2], control[1]
//   overflow      : sticky flag, set when a sample is dropped on back-pressure
//   state         : FSM state (IDLE/ARM/STREAM/DRAIN)
//   m00_axis_*    : stream master (tvalid/tdata/tstrb/tlast out, tready in)
module adc_to_axis_m
    import adc_axis_pkg::*;
#(
    parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned C_ADC_CLK_DIV          = 4,
    parameter int unsigned C_FRAME_LEN            = 1024
) (
    input  logic                                  m00_axis_aclk,
    input  logic                                  m00_axis_aresetn,
    input  logic [3:0]                            control,
    input  logic [ADC_W-1:0]                      ADC_data,
    output logic                                  ClockToADC,
    output logic                                  ADC_powerdown,
    output logic                                  LNA_enable,
    output logic                                  overflow,
    output logic [2:0]                            state,
    output logic                                  m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  m00_axis_tlast,
    input  logic                                  m00_axis_tready
);

    localparam int unsigned BEAT_W = (C_FRAME_LEN > 2) ? $clog2(C_FRAME_LEN) : 1;

    state_e            state_q;
    state_e            state_d;
    beat_t             beat_q;
    logic              tvalid_q;
    logic              overflow_q;
    logic [BEAT_W-1:0] beat_cnt_q;
    logic [ADC_W-1:0]  test_cnt_q;
    logic              strobe;

    logic              hs_c;
    logic              last_hs_c;
    logic              enter_arm_c;
    logic              capture_c;
    logic              load_c;
    logic              drop_c;
    logic [ADC_W-1:0]  sample_c;

    adc_clk_div #(
        .DIV (C_ADC_CLK_DIV)
    ) u_clk_div (
        .clk     (m00_axis_aclk),
        .rst_n   (m00_axis_aresetn),
        .clk_adc (ClockToADC),
        .strobe  (strobe)
    );

    // Handshake, capture and drop qualifiers.
    always_comb begin
        hs_c        = tvalid_q & m00_axis_tready;
        last_hs_c   = hs_c & beat_q.tlast;
        enter_arm_c = (state_q == ST_IDLE) & control[0];
        sample_c    = control[3] ? test_cnt_q : ADC_data;
        // In DRAIN, capture stops once the frame's final beat is in the register.
        capture_c   = strobe & ((state_q == ST_ARM) | (state_q == ST_STREAM) |
                                ((state_q == ST_DRAIN) & ~(tvalid_q & beat_q.tlast)));
        load_c      = capture_c & (~tvalid_q | m00_axis_tready);
        drop_c      = capture_c & tvalid_q & ~m00_axis_tready;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (control[0])  state_d = ST_ARM;
            ST_ARM:    if (strobe)      state_d = ST_STREAM;
            ST_STREAM: if (!control[0]) state_d = ST_DRAIN;
            ST_DRAIN:  if (last_hs_c)   state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output register, beat/test counters and overflow flag.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            beat_q     <= '0;
            tvalid_q   <= 1'b0;
            overflow_q <= 1'b0;
            beat_cnt_q <= '0;
            test_cnt_q <= '0;
        end else begin
            if (load_c) begin
                beat_q.tdata <= offset_to_twos(sample_c);
                beat_q.tlast <= (beat_cnt_q == BEAT_W'(C_FRAME_LEN - 1));
                tvalid_q     <= 1'b1;
                if (beat_cnt_q == BEAT_W'(C_FRAME_LEN - 1)) begin
                    beat_cnt_q <= '0;
                end else begin
                    beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                end
            end else if (hs_c) begin
                tvalid_q     <= 1'b0;
                beat_q.tlast <= 1'b0;
            end

            if (enter_arm_c) begin
                beat_cnt_q <= '0;
                overflow_q <= 1'b0;
            end else if (drop_c) begin
                overflow_q <= 1'b1;
            end

            if (enter_arm_c) begin
                test_cnt_q <= '0;
            end else if (strobe) begin
                test_cnt_q <= test_cnt_q + ADC_W'(1);
            end
        end
    end

    assign state           = state_q;
    assign overflow        = overflow_q;
    assign m00_axis_tvalid = tvalid_q;
    assign m00_axis_tdata  = C_M00_AXIS_TDATA_WIDTH'(beat_q.tdata);
    assign m00_axis_tlast  = beat_q.tlast;
    assign m00_axis_tstrb  = '1;

    // Analog front-end controls are plain pass-throughs.
    assign ADC_powerdown   = control[2];
    assign LNA_enable      = control[1];

endmodule

// File: tb/tb_adc_to_axis_m.sv
module tb_adc_to_axis_m;

    localparam int DIV = 4;
    localparam int FL  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  control;
    logic [13:0] adc_data;
    logic        clk_adc, pwdn, lna, ovf;
    logic [2:0]  state;
    logic        tvalid, tlast, tready;
    logic [31:0] tdata;
    logic [3:0]  tstrb;

    adc_to_axis_m #(
        .C_M00_AXIS_TDATA_WIDTH (32),
        .C_ADC_CLK_DIV          (DIV),
        .C_FRAME_LEN            (FL)
    ) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst_n),
        .control          (control),
        .ADC_data         (adc_data),
        .ClockToADC       (clk_adc),
        .ADC_powerdown    (pwdn),
        .LNA_enable       (lna),
        .overflow         (ovf),
        .state            (state),
        .m00_axis_tvalid  (tvalid),
        .m00_axis_tdata   (tdata),
        .m00_axis_tstrb   (tstrb),
        .m00_axis_tlast   (tlast),
        .m00_axis_tready  (tready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int S_IDLE = 0, S_ARM = 1, S_STREAM = 2, S_DRAIN = 3;
    int          m_phase  = 0;   // position within the ADC period
    int          m_state  = 0;
    int          m_tc     = 0;   // test-pattern counter
    int          m_loaded = 0;   // beats loaded since arming
    logic        m_valid  = 1'b0;
    logic        m_last   = 1'b0;
    logic        m_ovf    = 1'b0;
    logic [31:0] m_data   = '0;

    always @(posedge clk or negedge rst_n) begin : model
        int smp;
        bit stb, hs, cap, arm_in;
        if (!rst_n) begin
            m_phase <= 0; m_state <= S_IDLE; m_tc <= 0; m_loaded <= 0;
            m_valid <= 1'b0; m_last <= 1'b0; m_ovf <= 1'b0; m_data <= '0;
        end else begin
            stb    = (m_phase == DIV - 1);
            hs     = m_valid && tready;
            arm_in = (m_state == S_IDLE) && control[0];
            smp    = control[3] ? m_tc : int'(adc_data);
            cap    = stb && (m_state == S_ARM || m_state == S_STREAM ||
                             (m_state == S_DRAIN && !(m_valid && m_last)));
            if (cap && (!m_valid || tready)) begin
                m_data   <= 32'(smp - 8192);   // offset binary -> signed value
                m_last   <= ((m_loaded % FL) == FL - 1);
                m_loaded <= m_loaded + 1;
                m_valid  <= 1'b1;
            end else if (cap) begin
                m_ovf <= 1'b1;
            end else if (hs) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
            if (arm_in) begin
                m_ovf <= 1'b0; m_loaded <= 0; m_tc <= 0;
            end else if (stb) begin
                m_tc <= (m_tc + 1) % 16384;
            end
            case (m_state)
                S_IDLE:   if (control[0])      m_state <= S_ARM;
                S_ARM:    if (stb)             m_state <= S_STREAM;
                S_STREAM: if (!control[0])     m_state <= S_DRAIN;
                default:  if (hs && m_last)    m_state <= S_IDLE;
            endcase
            m_phase <= (m_phase + 1) % DIV;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("ClockToADC", {31'b0, clk_adc}, {31'b0, m_phase >= DIV / 2});
        chk("state", {29'b0, state}, 32'(m_state));
        chk("tvalid", {31'b0, tvalid}, {31'b0, m_valid});
        chk("overflow", {31'b0, ovf}, {31'b0, m_ovf});
        chk("tstrb", {28'b0, tstrb}, 32'hF);
        chk("pwdn_lna", {30'b0, pwdn, lna}, {30'b0, control[2], control[1]});
        if (m_valid || !rst_n) begin
            chk("tdata", tdata, m_data);
            chk("tlast", {31'b0, tlast}, {31'b0, m_last});
        end
    end

    // Handshake log for directed literal checks.
    typedef struct { logic [31:0] d; logic l; int c; } hs_t;
    hs_t hlog[$];
    always @(negedge clk) begin
        if (rst_n && tvalid && tready) hlog.push_back('{d: tdata, l: tlast, c: cyc});
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_log(input int n, input string name);
        int k = 0;
        while (hlog.size() < n && k < 200) begin step(); k++; end
        chk(name, 32'(hlog.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (!(state == 3'd0 && !tvalid) && k < 400) begin step(); k++; end
        chk(name, {29'b0, state}, 32'd0);
    endtask

    initial begin
        int nl;
        rst_n = 1'b0; control = 4'b0; adc_data = '0; tready = 1'b1;
        repeat (10) step();
        chk("rst tvalid", {31'b0, tvalid}, 32'd0);
        chk("rst tdata", tdata, 32'd0);
        chk("rst clk_adc", {31'b0, clk_adc}, 32'd0);
        chk("rst ovf_last", {30'b0, ovf, tlast}, 32'd0);
        rst_n = 1'b1;

        // Real data conversion, one beat per ADC period.
        hlog.delete();
        control = 4'b0001; adc_data = 14'h0000;
        wait_log(1, "s2 beat0 wait");
        adc_data = 14'h3FFF;
        wait_log(2, "s2 beat1 wait");
        chk("s2 beat0", hlog[0].d, 32'hFFFFE000);
        chk("s2 beat1", hlog[1].d, 32'h00001FFF);
        chk("s2 spacing", 32'(hlog[1].c - hlog[0].c), 32'd4);
        control = 4'b0000;
        wait_idle("s2 idle");

        // Test pattern, full frame.
        hlog.delete();
        control = 4'b1001;
        wait_log(4, "s3 wait");
        for (int i = 0; i < 4; i++) begin
            chk("s3 data", hlog[i].d, 32'hFFFFE000 + 32'(i));
            chk("s3 last", {31'b0, hlog[i].l}, 32'(i == 3));
        end
        control = 4'b1000;
        wait_idle("s3 idle");

        // Back-pressure across three strobes.
        hlog.delete();
        control = 4'b1001;
        wait_log(2, "s4 wait");
        chk("s4 ovf clear", {31'b0, ovf}, 32'd0);
        tready = 1'b0;
        repeat (12) step();
        chk("s4 ovf set", {31'b0, ovf}, 32'd1);
        chk("s4 held data", tdata, 32'hFFFFE002);
        chk("s4 held valid", {30'b0, tvalid, tlast}, 32'd2);
        tready = 1'b1;
        wait_log(4, "s4 wait2");
        chk("s4 beat2", hlog[2].d, 32'hFFFFE002);
        chk("s4 beat3", hlog[3].d, 32'hFFFFE005);
        chk("s4 beat3 last", {31'b0, hlog[3].l}, 32'd1);
        control = 4'b1000;
        wait_idle("s4 idle");

        // Enable dropped mid-frame: frame still completes.
        hlog.delete();
        control = 4'b1001;
        wait_log(2, "s5 wait");
        control = 4'b1000;
        step();
        chk("s5 drain", {29'b0, state}, 32'd3);
        wait_log(4, "s5 wait2");
        chk("s5 beat2", hlog[2].d, 32'hFFFFE002);
        chk("s5 beat3", hlog[3].d, 32'hFFFFE003);
        chk("s5 last", {31'b0, hlog[3].l}, 32'd1);
        wait_idle("s5 idle");
        repeat (10) step();
        chk("s5 no extra", 32'(hlog.size()), 32'd4);

        // Reset mid-frame abandons the frame.
        hlog.delete();
        control = 4'b1001;
        wait_log(2, "s6 wait");
        begin
            int k = 0;
            while (!tvalid && k < 20) begin step(); k++; end
        end
        rst_n = 1'b0;
        #1;
        chk("s6 rst tvalid", {31'b0, tvalid}, 32'd0);
        chk("s6 rst state", {29'b0, state}, 32'd0);
        nl = 0;
        foreach (hlog[i]) if (hlog[i].l) nl++;
        chk("s6 no tlast", 32'(nl), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        hlog.delete();
        wait_log(1, "s6 wait2");
        chk("s6 restart data", hlog[0].d, 32'hFFFFE000);
        chk("s6 restart last", {31'b0, hlog[0].l}, 32'd0);
        control = 4'b0000;
        wait_idle("s6 idle");

        // Randomised traffic checked cycle by cycle against the model.
        control = 4'b0001;
        for (int i = 0; i < 3000; i++) begin
            adc_data = 14'($urandom);
            tready   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) control[0] = ~control[0];
            if ($urandom_range(0, 99) == 0) control[3:1] = 3'($urandom);
            if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            step();
        end
        rst_n = 1'b1; control = 4'b0000; tready = 1'b1;
        wait_idle("final idle");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/adc_to_axis_m.md
ADC_TO_AXIS_M -- requirements
Module: adc_to_axis_m

Interface
REQ-001 Parameters SHALL be, one per line:
- C_M00_AXIS_TDATA_WIDTH, 32, stream word width (fixed at 32).
- C_ADC_CLK_DIV, 4, aclk cycles per ADC clock period; even, at least 2.
- C_FRAME_LEN, 1024, beats per frame; at least 2.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- m00_axis_aclk, in, 1, sole clock.
- m00_axis_aresetn, in, 1, asynchronous active-low reset.
- control, in, 4: bit0 capture enable; bit1 LNA enable; bit2 ADC powerdown; bit3 test mode.
- ADC_data, in, 14, offset-binary sample from the ADC.
- ClockToADC, out, 1, ADC conversion clock.
- ADC_powerdown, out, 1, equal to control[2].
- LNA_enable, out, 1, equal to control[1].
- overflow, out, 1, sticky sample-drop flag.
- state, out, 3, FSM state encoding.
- m00_axis_tvalid, out, 1, stream valid.
- m00_axis_tdata, out, 32, stream data.
- m00_axis_tstrb, out, 4, constant 4'hF.
- m00_axis_tlast, out, 1, last beat of a frame.
- m00_axis_tready, in, 1, downstream ready.

Function
REQ-003 Divider counter cnt SHALL run 0..C_ADC_CLK_DIV-1 and wrap continuously while reset is deasserted.
REQ-004 ClockToADC SHALL be 1 when cnt >= C_ADC_CLK_DIV/2 and 0 otherwise.
REQ-005 Strobe SHALL be asserted exactly in cycles where cnt == C_ADC_CLK_DIV-1, i.e. one cycle per ADC period, just before the ClockToADC fall.
REQ-006 Sample word SHALL be {18 copies of ~s[13], ~s[13], s[12:0]}: MSB inverted, then sign-extended (offset binary to two's complement).
REQ-007 Source s SHALL be ADC_data when control[3]=0, and a 14-bit test counter when control[3]=1.
REQ-008 Test counter SHALL increment on each strobe, wrap from 16383 to 0, and clear on entry to ARM.
REQ-009 FSM states SHALL be IDLE=0, ARM=1, STREAM=2, DRAIN=3.
REQ-010 IDLE SHALL go to ARM when control[0]=1.
REQ-011 ARM SHALL go to STREAM on the next strobe; that strobe's sample is beat 0 of the frame.
REQ-012 STREAM SHALL go to DRAIN when control[0]=0.
REQ-013 DRAIN SHALL keep capturing and go to IDLE on the cycle in which the tlast beat handshakes (tvalid & tready & tlast), so frames always complete.
REQ-014 On a strobe in STREAM or DRAIN, the sample SHALL be loaded into the output register with tvalid=1 at that clock edge, giving one-edge latency from ADC_data to tdata.
REQ-015 When a strobe coincides with tvalid & tready, the beat SHALL be accepted and the new sample loaded in the same edge, with tvalid remaining 1.
REQ-016 When a strobe coincides with tvalid & ~tready, the sample SHALL be dropped, tdata/tvalid/tlast held, and overflow set to 1.
REQ-017 The beat counter SHALL count only loaded beats; dropped samples are not counted.
REQ-018 tlast SHALL be 1 on beat index C_FRAME_LEN-1, after which the beat counter wraps to 0.
REQ-019 tvalid SHALL clear on handshake when no strobe coincides.
REQ-020 Once tvalid=1, tdata and tlast SHALL stay stable until handshake.
REQ-021 overflow SHALL clear only on entry to ARM.
REQ-022 No beats SHALL be produced in IDLE or ARM.

Reset
REQ-023 While m00_axis_aresetn=0, outputs SHALL be: tvalid=0, tlast=0, tdata=0, overflow=0, ClockToADC=0, state=IDLE.
REQ-024 While m00_axis_aresetn=0, cnt, the beat counter and the test counter SHALL be 0.
REQ-025 Reset mid-frame SHALL abandon the partial frame with no tlast emitted.
REQ-026 After reset release, the divider SHALL restart from cnt=0.

Structure
REQ-027 Package adc_axis_pkg SHALL hold state encodings, ADC width 14, and the offset-to-two's-complement conversion function.
REQ-028 Sub-module adc_clk_div SHALL generate ClockToADC and strobe.
REQ-029 FSM, output register and counters SHALL reside in adc_to_axis_m.

Verification
REQ-030 Bench SHALL cover these directed scenarios:
- Reset, then hold reset 10 cycles -> all outputs 0, ClockToADC static 0.
- DIV=4, ADC_data=14'h0000 then 14'h3FFF, tready=1 -> tdata 0xFFFFE000, then 0x00001FFF, one beat per 4 cycles.
- Test mode, FRAME_LEN=4, tready=1 -> tdata 0xFFFFE000, 0xFFFFE001, 0xFFFFE002, 0xFFFFE003; tlast on the 4th beat.
- tready=0 for 3 strobes mid-frame -> first sample held, overflow=1, 2 samples dropped, beat count unchanged.
- control[0] dropped at beat 1 of FRAME_LEN=4 -> DRAIN, beats 2 and 3 delivered, tlast, then IDLE.
- Reset asserted at beat 2 -> tvalid=0 immediately; after re-enable, frame restarts at beat 0 and test counter restarts at 0.
